fxp_vector_converter: RTL and testbench
=======================================

# fxp_vector_converter

Streaming, parametrised fixed-point format converter for D-element vectors. It generalises the package-level `rms_in2internal`/`rms_internal2out` shift-only conversions by adding arbitrary input/output widths and exponents, selectable rounding, optional saturation, vector framing and per-vector saturation counting. It sits between the vector register file and functional units whose internal format differs from `fixed_point_t`, such as the RMS unit. It handles one element per beat over a valid/ready stream with a 2-stage pipeline.

## Interface
Parameters:
- `IN_W`, 8, input element width (signed).
- `IN_EXP`, -3, input binary exponent.
- `OUT_W`, 9, output element width (signed).
- `OUT_EXP`, 0, output binary exponent.
- `D`, 16, elements per vector; must be ≥ 2.

Ports:
- `clk_i`, in, 1, sole clock; all logic is rising-edge.
- `rst_i`, in, 1, reset; synchronous, active-high.
- `round_i`, in, 1, 0 = truncate (floor), 1 = round half up.
- `sat_en_i`, in, 1, 1 = saturate, 0 = wrap (keep low `OUT_W` bits).
- `in_valid_i`, in, 1, input element valid.
- `in_ready_o`, out, 1, converter accepts an element this cycle.
- `in_data_i`, in, `IN_W`, signed input element.
- `out_valid_o`, out, 1, output element valid.
- `out_ready_i`, in, 1, downstream accepts.
- `out_data_o`, out, `OUT_W`, converted element.
- `out_last_o`, out, 1, element is index D-1 of its vector.
- `out_sat_o`, out, 1, this element was clipped; only asserted when `sat_en` is active.
- `sat_count_o`, out, `$clog2(D+1)`, clipped elements in the vector; valid only with `out_last_o`, 0 otherwise.

## Operation
- Shift amount: `S = IN_EXP - OUT_EXP`.
  - S ≥ 0: sign-extend the input, then shift left by S.
  - S < 0: arithmetic right shift by -S.
- Rounding (S < 0 and round set): add 2^(-S-1) before the shift. Otherwise rounding is ignored.
- Internal width is `IN_W + |S| + 1`, so no intermediate overflow can occur.
- Saturation (sat set):
  - result > 2^(OUT_W-1)-1 → max, `out_sat_o` = 1.
  - result < -2^(OUT_W-1) → min, `out_sat_o` = 1.
- Wrap (sat clear): take the low `OUT_W` bits; `out_sat_o` = 0.
- Mode latch:
  - `round_i` and `sat_en_i` are sampled when element index 0 is accepted.
  - The sampled values are held for the whole vector. Changes mid-vector take effect at the next vector.
- Element counter:
  - Increments on each input handshake (`in_valid_i && in_ready_o`).
  - Wraps from D-1 to 0.
  - Its index travels with the data; index D-1 sets `out_last_o`.
- Saturation counter:
  - Accumulates `out_sat_o` over the vector's elements.
  - `sat_count_o` presents the total including the last element, on the last beat.
  - The counter clears to 0 for the next vector.
- Pipeline:
  - Stage 1 registers the shifted/rounded value, index and mode.
  - Stage 2 registers the clamped/wrapped output, flags and count.
- Reset clears both valids, the element counter, the saturation counter and the mode latch.
  - A vector in flight at reset is discarded.
  - The next accepted element is index 0.

## Timing
- Reset values of outputs:
  - `in_ready_o` = 1.
  - `out_valid_o`, `out_last_o` and `out_sat_o` = 0.
  - `out_data_o` = 0 and `sat_count_o` = 0.
- Latency: an element accepted in cycle N appears at `out_valid_o` in cycle N+2 when there is no stall.
- Throughput: 1 element/cycle while `out_ready_i` stays high.
- Stage advance rules:
  - Stage 2 loads when it is empty or `out_ready_i` = 1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - `in_ready_o = !s1_valid || s2_load`, a combinational path from `out_ready_i`.
- Output hold: while `out_valid_o` && !`out_ready_i`, all `out_*` signals are held stable.
- No bubbles are inserted. When `out_ready_i` returns, a full pipeline drains 1 element/cycle.
- Handshakes at input and output may occur in the same cycle.
- Simultaneous events:
  - A last beat and a new index 0 can both be in the pipe.
  - The count clear and the first accumulation of the next vector happen without loss.

## Test plan
- **Default params, truncate, wrap mode.** Input 20 → 2; input -20 → -3; input 0 → 0. Latency is exactly 2 cycles.
- **Default params, round mode.** Input 20 → 3; input -20 → -2; input 4 → 1; input -4 → 0.
- **OUT_W=4, OUT_EXP=-3 (S=0), saturate.**
  - Input 100 → 7; input -100 → -8; `out_sat_o` = 1 on both.
  - Same inputs with wrap: 100 → 4, -100 → -4, `out_sat_o` = 0.
- **Framing and count.**
  - Stream 2 vectors of D=16 with elements 0,0,100 (OUT_W=4 saturate) patterns.
  - `out_last_o` is high on beats 15 and 31 only.
  - `sat_count_o` equals the exact clipped count on those beats and is 0 elsewhere.
- **Backpressure.**
  - Drive random `out_ready_i` toggling with a continuous input.
  - All 64 elements arrive in order with no loss or duplication.
  - Outputs are stable during stalls.
  - `in_ready_o` drops only when both stages are full and stalled.
- **Mode change mid-vector and reset.**
  - Flip `round_i` at element 5: the vector keeps the old mode and the next vector uses the new one.
  - Assert `rst_i` at element 7: the outputs go to reset values next cycle and the next element is tagged index 0.

Source files
------------

// File: rtl/fxp_vector_converter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : fxp_vector_converter                                         |
// | Description : Streaming signed fixed-point format converter for D-element  |
// |               vectors. One element per beat over valid/ready, 2-stage      |
// |               pipeline (scale/round, then clamp-or-wrap), per-vector       |
// |               framing and saturation counting.                             |
// | Ports       : clk_i, rst_i      - clock, synchronous active-high reset     |
// |               round_i, sat_en_i - rounding / saturation mode, sampled at   |
// |                                   element 0 and held for the vector        |
// |               in_*              - input element stream (valid/ready/data)  |
// |               out_*             - converted element stream with last flag, |
// |                                   per-element clip flag                    |
// |               sat_count_o       - clipped elements of the vector, shown    |
// |                                   on the last beat only                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fxp_vector_converter #(
  parameter int IN_W    = 8,
  parameter int IN_EXP  = -3,
  parameter int OUT_W   = 9,
  parameter int OUT_EXP = 0,
  parameter int D       = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     round_i,
  input  logic                     sat_en_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [IN_W-1:0]          in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [OUT_W-1:0]         out_data_o,
  output logic                     out_last_o,
  output logic                     out_sat_o,
  output logic [$clog2(D+1)-1:0]   sat_count_o
);

  // Scaling geometry. The internal width carries the full shifted value plus
  // one guard bit so the rounding bias can never overflow.
  localparam int c_shift     = IN_EXP - OUT_EXP;
  localparam int c_abs_shift = (c_shift < 0) ? -c_shift : c_shift;
  localparam int c_int_w     = IN_W + c_abs_shift + 1;
  // Compare width is strictly wider than both the internal and output widths
  // so the clamp limits are representable as signed values.
  localparam int c_cmp_w     = ((c_int_w > OUT_W) ? c_int_w : OUT_W) + 1;
  localparam int c_idx_w     = $clog2(D);
  localparam int c_cnt_w     = $clog2(D + 1);
  // Half an output LSB, only meaningful when bits are shifted out.
  localparam int c_half_int  = (c_shift < 0) ? (2 ** (c_abs_shift - 1)) : 0;

  localparam logic signed [c_int_w-1:0] c_half     = c_int_w'(c_half_int);
  localparam logic [c_idx_w-1:0]        c_last_idx = c_idx_w'(D - 1);
  localparam logic signed [c_cmp_w-1:0] c_max =
    {{(c_cmp_w - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [c_cmp_w-1:0] c_min =
    {{(c_cmp_w - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  // Handshake / element counter / mode latch
  logic [c_idx_w-1:0] r_idx;
  logic               r_mode_round;
  logic               r_mode_sat;
  logic               w_accept;
  logic               w_s1_load;
  logic               w_s2_load;
  logic               w_round;
  logic               w_sat;

  // Stage 1
  logic signed [c_int_w-1:0] w_ext;
  logic signed [c_int_w-1:0] w_biased;
  logic signed [c_int_w-1:0] w_scaled;
  logic                      r_s1_valid;
  logic signed [c_int_w-1:0] r_s1_data;
  logic                      r_s1_last;
  logic                      r_s1_sat_mode;

  // Stage 2
  logic signed [c_cmp_w-1:0] w_wide;
  logic                      w_over;
  logic                      w_under;
  logic [OUT_W-1:0]          w_out_data;
  logic                      w_out_sat;
  logic [c_cnt_w-1:0]        w_acc_next;
  logic                      r_out_valid;
  logic [OUT_W-1:0]          r_out_data;
  logic                      r_out_last;
  logic                      r_out_sat;
  logic [c_cnt_w-1:0]        r_sat_count;
  logic [c_cnt_w-1:0]        r_sat_acc;

  assign w_s2_load  = !r_out_valid || out_ready_i;
  assign w_s1_load  = !r_s1_valid || w_s2_load;
  assign in_ready_o = w_s1_load;
  assign w_accept   = in_valid_i && w_s1_load;

  // Element 0 uses the live mode pins; later elements use the value latched
  // when element 0 was accepted, so mid-vector changes wait for the next one.
  assign w_round = (r_idx == '0) ? round_i  : r_mode_round;
  assign w_sat   = (r_idx == '0) ? sat_en_i : r_mode_sat;

  assign w_ext    = {{(c_abs_shift + 1){in_data_i[IN_W-1]}}, in_data_i};
  assign w_biased = w_ext + (w_round ? c_half : {c_int_w{1'b0}});

  generate
    if (c_shift >= 0) begin : g_shift_left
      assign w_scaled = w_biased <<< c_abs_shift;
    end else begin : g_shift_right
      assign w_scaled = w_biased >>> c_abs_shift;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx         <= '0;
      r_mode_round  <= 1'b0;
      r_mode_sat    <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_s1_data     <= '0;
      r_s1_last     <= 1'b0;
      r_s1_sat_mode <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
        if (r_idx == '0) begin
          r_mode_round <= round_i;
          r_mode_sat   <= sat_en_i;
        end
      end
      if (w_s1_load) begin
        r_s1_valid <= in_valid_i;
        if (in_valid_i) begin
          r_s1_data     <= w_scaled;
          r_s1_last     <= (r_idx == c_last_idx);
          r_s1_sat_mode <= w_sat;
        end
      end
    end
  end

  assign w_wide  = {{(c_cmp_w - c_int_w){r_s1_data[c_int_w-1]}}, r_s1_data};
  assign w_over  = (w_wide > c_max);
  assign w_under = (w_wide < c_min);

  always_comb begin
    w_out_data = w_wide[OUT_W-1:0];
    w_out_sat  = 1'b0;
    if (r_s1_sat_mode) begin
      if (w_over) begin
        w_out_data = c_max[OUT_W-1:0];
        w_out_sat  = 1'b1;
      end else if (w_under) begin
        w_out_data = c_min[OUT_W-1:0];
        w_out_sat  = 1'b1;
      end
    end
  end

  assign w_acc_next = r_sat_acc + {{(c_cnt_w - 1){1'b0}}, w_out_sat};

  // The accumulator restarts from zero in the same cycle the last beat is
  // loaded, so an element 0 following directly behind is counted afresh.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sat   <= 1'b0;
      r_sat_count <= '0;
      r_sat_acc   <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_out_data;
        r_out_last <= r_s1_last;
        r_out_sat  <= w_out_sat;
        if (r_s1_last) begin
          r_sat_count <= w_acc_next;
          r_sat_acc   <= '0;
        end else begin
          r_sat_count <= '0;
          r_sat_acc   <= w_acc_next;
        end
      end else begin
        r_out_last  <= 1'b0;
        r_out_sat   <= 1'b0;
        r_sat_count <= '0;
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;
  assign out_sat_o   = r_out_sat;
  assign sat_count_o = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_fxp_vector_converter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_fxp_vector_converter                                      |
// | Description : Self-checking bench for fxp_vector_converter. Instance a     |
// |               uses default parameters (S=-3, OUT_W=9); instance b uses     |
// |               OUT_W=4, OUT_EXP=-3 (S=0) for saturation scenarios.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fxp_vector_converter;
  localparam int D = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       a_round = 0, a_sat = 0, a_in_valid = 0, a_out_ready = 0;
  logic [7:0] a_in_data = '0;
  logic       a_in_ready, a_out_valid, a_out_last, a_out_sat;
  logic [8:0] a_out_data;
  logic [4:0] a_sat_count;
  logic       b_round = 0, b_sat = 0, b_in_valid = 0, b_out_ready = 0;
  logic [7:0] b_in_data = '0;
  logic       b_in_ready, b_out_valid, b_out_last, b_out_sat;
  logic [3:0] b_out_data;
  logic [4:0] b_sat_count;

  fxp_vector_converter dut_a (
    .clk_i(clk), .rst_i(rst), .round_i(a_round), .sat_en_i(a_sat),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .out_last_o(a_out_last), .out_sat_o(a_out_sat), .sat_count_o(a_sat_count)
  );

  fxp_vector_converter #(.IN_W(8), .IN_EXP(-3), .OUT_W(4), .OUT_EXP(-3), .D(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .round_i(b_round), .sat_en_i(b_sat),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_last_o(b_out_last), .out_sat_o(b_out_sat), .sat_count_o(b_sat_count)
  );

  typedef struct {
    logic              in_ready;
    logic              valid;
    logic signed [31:0] data;
    logic              last;
    logic              sat;
    logic [31:0]       cnt;
    logic              in_hs;
    logic              out_hs;
  } obs_t;

  typedef struct {
    int val;
    bit sat;
    bit last;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   m_idx, m_acc;
  bit   m_rnd, m_sat;
  int   checks = 0;
  int   passed = 0;

  // Reference conversion from the numeric definition: value * 2^S, floored
  // (or floored after adding one half), then clamped or taken modulo 2^OUT_W.
  function automatic int ref_conv(int x, bit rnd, bit st, bit sel, output bit clip);
    int out_w, s, q, num, den, maxv, minv, m;
    out_w = sel ? 4 : 9;
    s     = sel ? 0 : -3;
    if (s >= 0) begin
      q = x * (2 ** s);
    end else begin
      den = 2 ** (-s);
      num = rnd ? x * 2 + den : x * 2;   // doubled to keep the half exact
      den = den * 2;
      q = num / den;
      if (num < 0 && (num % den) != 0) q = q - 1;
    end
    maxv = (2 ** (out_w - 1)) - 1;
    minv = -(2 ** (out_w - 1));
    clip = 1'b0;
    if (st) begin
      if (q > maxv) begin q = maxv; clip = 1'b1; end
      else if (q < minv) begin q = minv; clip = 1'b1; end
    end else begin
      m = 2 ** out_w;
      q = ((q % m) + m) % m;
      if (q > maxv) q = q - m;
    end
    return q;
  endfunction

  task automatic model_reset();
    m_idx = 0;
    m_acc = 0;
    exp_q.delete();
  endtask

  task automatic model_push(bit sel, int x, bit rnd, bit st);
    exp_t e;
    bit   c;
    if (m_idx == 0) begin
      m_rnd = rnd;
      m_sat = st;
    end
    e.val  = ref_conv(x, m_rnd, m_sat, sel, c);
    e.sat  = c;
    m_acc  = m_acc + int'(c);
    e.last = (m_idx == D - 1);
    e.cnt  = e.last ? m_acc : 0;
    if (e.last) begin
      m_acc = 0;
      m_idx = 0;
    end else begin
      m_idx = m_idx + 1;
    end
    exp_q.push_back(e);
  endtask

  // Drive one cycle on the selected instance and observe its outputs just
  // after the inputs settle, before the rising edge that consumes them.
  task automatic step(input bit sel, input bit r, input bit iv, input logic [7:0] d,
                      input bit ordy, input bit rnd, input bit st, output obs_t o);
    @(negedge clk);
    rst         = r;
    a_in_valid  = !sel && iv;
    b_in_valid  = sel && iv;
    a_in_data   = d;
    b_in_data   = d;
    a_out_ready = sel ? 1'b1 : ordy;
    b_out_ready = sel ? ordy : 1'b1;
    a_round = rnd; b_round = rnd;
    a_sat   = st;  b_sat   = st;
    #1;
    if (sel) begin
      o.in_ready = b_in_ready; o.valid = b_out_valid;
      o.data = {{28{b_out_data[3]}}, b_out_data};
      o.last = b_out_last; o.sat = b_out_sat; o.cnt = {27'b0, b_sat_count};
    end else begin
      o.in_ready = a_in_ready; o.valid = a_out_valid;
      o.data = {{23{a_out_data[8]}}, a_out_data};
      o.last = a_out_last; o.sat = a_out_sat; o.cnt = {27'b0, a_sat_count};
    end
    o.in_hs  = iv && (o.in_ready === 1'b1) && !r;
    o.out_hs = (o.valid === 1'b1) && ordy && !r;
    @(posedge clk);
  endtask

  task automatic test_reset();
    obs_t o;
    step(0, 1, 0, 8'h00, 1, 0, 0, o);
    step(0, 1, 0, 8'h00, 1, 0, 0, o);
    for (int s = 0; s < 2; s++) begin
      step(s[0], 0, 0, 8'h00, 1, 0, 0, o);
      checks++; if (o.in_ready !== 1'b1) $display("FAIL reset in_ready[%0d] got %b want 1", s, o.in_ready); else passed++;
      checks++; if (o.valid !== 1'b0) $display("FAIL reset out_valid[%0d] got %b want 0", s, o.valid); else passed++;
      checks++; if (o.data !== 0) $display("FAIL reset out_data[%0d] got %0d want 0", s, o.data); else passed++;
      checks++; if (o.last !== 1'b0) $display("FAIL reset out_last[%0d] got %b want 0", s, o.last); else passed++;
      checks++; if (o.sat !== 1'b0) $display("FAIL reset out_sat[%0d] got %b want 0", s, o.sat); else passed++;
      checks++; if (o.cnt !== 0) $display("FAIL reset sat_count[%0d] got %0d want 0", s, o.cnt); else passed++;
    end
  endtask

  // Directed conversions embedded at the head of otherwise random vectors.
  task automatic test_convert();
    int   din[4][4], dexp[4][4], dn[4];
    bit   dsel[4], drnd[4], dsat[4], dclip[4];
    logic [7:0] stim[D];
    obs_t o;
    exp_t e;
    int   sent, got, cyc, acc_cyc, x;
    din  = '{'{20, -20, 0, 0}, '{20, -20, 4, -4}, '{100, -100, 0, 0}, '{100, -100, 0, 0}};
    dexp = '{'{2, -3, 0, 0},   '{3, -2, 1, 0},    '{7, -8, 0, 0},     '{4, -4, 0, 0}};
    dn    = '{3, 4, 2, 2};
    dsel  = '{0, 0, 1, 1};
    drnd  = '{0, 1, 0, 0};
    dsat  = '{0, 0, 1, 0};
    dclip = '{0, 0, 1, 0};
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < D; i++) stim[i] = (i < dn[t]) ? 8'(din[t][i]) : 8'($urandom_range(0, 255));
      model_reset();
      sent = 0; got = 0; cyc = 0; acc_cyc = -1;
      while (got < D && cyc < 200) begin
        step(dsel[t], 0, sent < D, (sent < D) ? stim[sent] : 8'h00, 1, drnd[t], dsat[t], o);
        if (o.out_hs) begin
          if (exp_q.size() == 0) begin
            checks++; $display("FAIL convert[%0d] extra output data=%0d", t, o.data);
          end else begin
            e = exp_q.pop_front();
            checks++; if (o.data !== e.val) $display("FAIL convert[%0d] data beat %0d got %0d want %0d", t, got, o.data, e.val); else passed++;
            checks++; if (o.sat !== e.sat) $display("FAIL convert[%0d] sat beat %0d got %b want %b", t, got, o.sat, e.sat); else passed++;
            checks++; if (o.last !== e.last) $display("FAIL convert[%0d] last beat %0d got %b want %b", t, got, o.last, e.last); else passed++;
            checks++; if (o.cnt !== e.cnt) $display("FAIL convert[%0d] count beat %0d got %0d want %0d", t, got, o.cnt, e.cnt); else passed++;
          end
          if (got < dn[t]) begin
            checks++; if (o.data !== dexp[t][got]) $display("FAIL convert[%0d] directed in=%0d got %0d want %0d", t, din[t][got], o.data, dexp[t][got]); else passed++;
            checks++; if (o.sat !== dclip[t]) $display("FAIL convert[%0d] directed sat in=%0d got %b want %b", t, din[t][got], o.sat, dclip[t]); else passed++;
          end
          if (got == 0 && t == 0) begin
            checks++; if (cyc - acc_cyc !== 2) $display("FAIL latency got %0d want 2", cyc - acc_cyc); else passed++;
          end
          got++;
        end
        if (o.in_hs) begin
          if (sent == 0) acc_cyc = cyc;
          x = $signed(stim[sent]);
          model_push(dsel[t], x, drnd[t], dsat[t]);
          sent++;
        end
        cyc++;
      end
      if (got < D) begin checks++; $display("FAIL convert[%0d] timeout got %0d want %0d outputs", t, got, D); end
    end
  endtask

  // Two back-to-back saturating vectors of the 0,0,100 pattern.
  task automatic test_framing();
    logic [7:0] stim[2*D];
    int   vcnt[2];
    obs_t o;
    exp_t e;
    int   sent, got, cyc, x;
    vcnt = '{0, 0};
    for (int g = 0; g < 2 * D; g++) begin
      stim[g] = (g % 3 == 2) ? 8'd100 : 8'd0;
      if (g % 3 == 2) vcnt[g / D] = vcnt[g / D] + 1;
    end
    model_reset();
    sent = 0; got = 0; cyc = 0;
    while (got < 2 * D && cyc < 200) begin
      step(1, 0, sent < 2 * D, (sent < 2 * D) ? stim[sent] : 8'h00, 1, 0, 1, o);
      if (o.out_hs) begin
        if (exp_q.size() == 0) begin
          checks++; $display("FAIL framing extra output data=%0d", o.data);
        end else begin
          e = exp_q.pop_front();
          checks++; if (o.data !== e.val) $display("FAIL framing data beat %0d got %0d want %0d", got, o.data, e.val); else passed++;
          checks++; if (o.sat !== e.sat) $display("FAIL framing sat beat %0d got %b want %b", got, o.sat, e.sat); else passed++;
        end
        checks++; if (o.last !== (got == D - 1 || got == 2 * D - 1)) $display("FAIL framing last beat %0d got %b", got, o.last); else passed++;
        checks++;
        if (o.cnt !== ((got % D == D - 1) ? vcnt[got / D] : 0)) $display("FAIL framing count beat %0d got %0d want %0d", got, o.cnt, (got % D == D - 1) ? vcnt[got / D] : 0);
        else passed++;
        got++;
      end
      if (o.in_hs) begin
        x = $signed(stim[sent]);
        model_push(1, x, 0, 1);
        sent++;
      end
      cyc++;
    end
    if (got < 2 * D) begin checks++; $display("FAIL framing timeout got %0d want %0d outputs", got, 2 * D); end
  endtask

  // Random output stalls, random per-cycle mode pins, continuous input.
  task automatic test_back_to_back_backpressure();
    obs_t o, pv;
    exp_t e;
    bit   ordy, pv_stall, exp_ir;
    int   sent, got, cyc, occ, x;
    logic [7:0] d;
    model_reset();
    sent = 0; got = 0; cyc = 0; occ = 0; pv_stall = 0;
    while (got < 64 && cyc < 1000) begin
      ordy = ($urandom_range(0, 99) < 55);
      case ($urandom_range(0, 5))
        0:       d = 8'h7f;
        1:       d = 8'h80;
        default: d = 8'($urandom_range(0, 255));
      endcase
      step(0, 0, sent < 64, d, ordy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
      exp_ir = (occ < 2) || ordy;
      checks++; if (o.in_ready !== exp_ir) $display("FAIL bp in_ready cyc %0d got %b want %b occ=%0d", cyc, o.in_ready, exp_ir, occ); else passed++;
      if (pv_stall) begin
        checks++;
        if (o.valid !== 1'b1 || o.data !== pv.data || o.last !== pv.last || o.sat !== pv.sat || o.cnt !== pv.cnt)
          $display("FAIL bp hold cyc %0d got v=%b d=%0d l=%b s=%b c=%0d want v=1 d=%0d l=%b s=%b c=%0d",
                   cyc, o.valid, o.data, o.last, o.sat, o.cnt, pv.data, pv.last, pv.sat, pv.cnt);
        else passed++;
      end
      if (o.out_hs) begin
        if (exp_q.size() == 0) begin
          checks++; $display("FAIL bp extra output data=%0d", o.data);
        end else begin
          e = exp_q.pop_front();
          checks++; if (o.data !== e.val) $display("FAIL bp data beat %0d got %0d want %0d", got, o.data, e.val); else passed++;
          checks++; if (o.sat !== e.sat) $display("FAIL bp sat beat %0d got %b want %b", got, o.sat, e.sat); else passed++;
          checks++; if (o.last !== e.last) $display("FAIL bp last beat %0d got %b want %b", got, o.last, e.last); else passed++;
          checks++; if (o.cnt !== e.cnt) $display("FAIL bp count beat %0d got %0d want %0d", got, o.cnt, e.cnt); else passed++;
        end
        got++;
      end
      if (o.in_hs) begin
        x = $signed(d);
        model_push(0, x, a_round, a_sat);
        sent++;
      end
      occ = occ + int'(o.in_hs) - int'(o.out_hs);
      pv = o;
      pv_stall = (o.valid === 1'b1) && !ordy;
      cyc++;
    end
    checks++; if (got !== 64) $display("FAIL bp element total got %0d want 64", got); else passed++;
    checks++; if (exp_q.size() !== 0) $display("FAIL bp leftover got %0d want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_mode_change_reset();
    logic [7:0] stim[2*D];
    obs_t o;
    exp_t e;
    int   sent, got, cyc, x, lim;
    for (int g = 0; g < 2 * D; g++) stim[g] = 8'($urandom_range(0, 255));
    stim[8]  = 8'd20;
    stim[16] = 8'd20;
    for (int phase = 0; phase < 3; phase++) begin
      // phase 0: round flips at element 5; 1: vector cut by reset; 2: fresh vector
      lim = (phase == 0) ? 2 * D : (phase == 1) ? 7 : D;
      model_reset();
      sent = 0; got = 0; cyc = 0;
      while (((phase == 1) ? (sent < lim) : (got < lim)) && cyc < 300) begin
        step(0, 0, sent < lim, (sent < lim) ? stim[sent] : 8'h00, 1, (phase == 0) && (sent >= 5), 0, o);
        if (o.out_hs) begin
          if (exp_q.size() == 0) begin
            checks++; $display("FAIL mode[%0d] extra output data=%0d", phase, o.data);
          end else begin
            e = exp_q.pop_front();
            checks++; if (o.data !== e.val) $display("FAIL mode[%0d] data beat %0d got %0d want %0d", phase, got, o.data, e.val); else passed++;
            checks++; if (o.last !== e.last) $display("FAIL mode[%0d] last beat %0d got %b want %b", phase, got, o.last, e.last); else passed++;
          end
          if (phase == 0 && got == 8) begin
            checks++; if (o.data !== 2) $display("FAIL mode old-mode 20 got %0d want 2", o.data); else passed++;
          end
          if (phase == 0 && got == 16) begin
            checks++; if (o.data !== 3) $display("FAIL mode new-mode 20 got %0d want 3", o.data); else passed++;
          end
          got++;
        end
        if (o.in_hs) begin
          x = $signed(stim[sent]);
          model_push(0, x, (phase == 0) && (sent >= 5), 0);
          sent++;
        end
        cyc++;
      end
      if (phase != 1 && got < lim) begin checks++; $display("FAIL mode[%0d] timeout got %0d want %0d", phase, got, lim); end
      if (phase == 1) begin
        step(0, 1, 1, stim[7], 1, 0, 0, o);
        step(0, 0, 0, 8'h00, 1, 0, 0, o);
        checks++; if (o.valid !== 1'b0) $display("FAIL mode reset out_valid got %b want 0", o.valid); else passed++;
        checks++; if (o.data !== 0) $display("FAIL mode reset out_data got %0d want 0", o.data); else passed++;
        checks++; if (o.last !== 1'b0 || o.sat !== 1'b0) $display("FAIL mode reset flags got last=%b sat=%b want 0", o.last, o.sat); else passed++;
        checks++; if (o.cnt !== 0) $display("FAIL mode reset sat_count got %0d want 0", o.cnt); else passed++;
        checks++; if (o.in_ready !== 1'b1) $display("FAIL mode reset in_ready got %b want 1", o.in_ready); else passed++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_convert();
    test_framing();
    test_back_to_back_backpressure();
    test_mode_change_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
